fp_norm_round: RTL and testbench
================================

FP_NORM_ROUND -- requirements
Module: fp_norm_round

Interface
REQ-001 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous reset, active-low; sampled on the rising edge of clock
- start  in  1  capture request; sampled only in IDLE
- sign_in  in  1  product sign (sign_a XOR sign_b)
- exp_in  in  10  two's-complement biased exponent ea+eb-127, assuming a product in [1,2)
- mant_in  in  48  raw 24x24 significand product, hidden bits included
- produto  out  32  packed IEEE-754 single-precision result
- done  out  1  one-cycle pulse; produto and flags valid
- busy  out  1  high whenever state is not IDLE
- overflow  out  1  result saturated to infinity
- underflow  out  1  result flushed to zero
REQ-002 The block SHALL have no parameters; all widths are fixed as listed.

Function
REQ-003 The FSM SHALL have states IDLE, NORM, ROUND, PACK, with one transition per clock: IDLE->NORM on start=1, NORM->ROUND, ROUND->PACK, PACK->IDLE.
REQ-004 On edge E0 (IDLE, start=1), the block SHALL register sign_in, exp_in and mant_in.
REQ-005 The block SHALL ignore start in NORM, ROUND and PACK, without queuing the request.
REQ-006 Fixed latency: start sampled at E0 -> produto, flags and done=1 registered at E3; done SHALL return to 0 at E4 unless a new result is being packed.
REQ-007 busy SHALL be 1 in NORM, ROUND and PACK, and 0 in IDLE.
REQ-008 NORM (edge E1), mant[47]=1: sig=mant[47:24], guard=mant[23], sticky=OR(mant[22:0]), exp=exp+1 (10-bit signed arithmetic).
REQ-009 NORM (edge E1), mant[47]=0: sig=mant[46:23], guard=mant[22], sticky=OR(mant[21:0]), exp unchanged.
REQ-010 NORM SHALL set an internal zero flag when mant_in=0.
REQ-011 ROUND (edge E2) SHALL apply round-to-nearest-even: increment the 25-bit {0,sig} when guard AND (sticky OR sig[0]).
REQ-012 In ROUND, if the 25-bit sum carries into bit 24, the block SHALL shift it right 1 and add 1 to exp.
REQ-013 PACK (edge E3) SHALL apply the first matching rule, in this priority order:
- zero flag: produto={sign,31'b0}, overflow=0, underflow=0
- exp>=255: produto={sign,8'hFF,23'b0}, overflow=1
- exp<=0 (signed): produto={sign,31'b0}, underflow=1; subnormals are not produced
- otherwise: produto={sign,exp[7:0],sig[22:0]}, both flags 0
REQ-014 produto, overflow and underflow SHALL hold their values until the next PACK or reset.
REQ-015 start=1 in the IDLE cycle where done=1 SHALL be accepted; the new operation proceeds independently of the completed one.
REQ-016 Exponent arithmetic SHALL be 10-bit two's complement; exp_in range -512..511 SHALL not wrap incorrectly for a +2 adjustment at the top of the range; values up to 513 SHALL be handled internally with 11 bits.

Reset
REQ-017 reset=0 at a rising edge SHALL force state=IDLE, produto=0, done=0, busy=0, overflow=0, underflow=0, and clear all internal registers.
REQ-018 Reset SHALL take priority over start and over any in-flight operation; an aborted operation SHALL produce no done pulse.

Verification
REQ-019 The bench SHALL cover these directed scenarios (sign_in=0 unless stated):
- 1.5*1.5: mant_in=48'h900000000000, exp_in=127, start at E0 -> E3: produto=32'h40100000, done=1 for exactly one cycle, busy=1 from E0 until E3.
- 1.0*1.0 and ties: mant_in=48'h400000000000, exp_in=127 -> 32'h3F800000.
- Tie, odd lsb: mant_in={1'b0,24'h800001,1'b1,22'b0} -> 32'h3F800002.
- Tie, even lsb: mant_in={1'b0,24'h800000,1'b1,22'b0} -> 32'h3F800000.
- Rounding carry-out: mant_in={1'b0,24'hFFFFFF,1'b1,22'b0}, exp_in=127 -> 32'h40000000.
- Overflow: mant_in=48'h900000000000, exp_in=254, sign_in=1 -> produto=32'hFF800000, overflow=1.
- Underflow: exp_in=10'h3F0 (-16), mant_in=48'h400000000000 -> produto=0, underflow=1.
- Zero: mant_in=0, sign_in=1 -> produto=32'h80000000, both flags 0.
- Reset mid-operation and back-to-back: reset=0 at E2 of an operation -> next cycle busy=0, done=0, produto=0, and no done pulse afterward.
- Back-to-back: start held high continuously -> done pulses every 4 cycles, each with the correct produto.

Source files
------------

// File: rtl/fp_norm_round.sv
`default_nettype none
// ============================================================================
//  Module   : fp_norm_round
//  Purpose  : Normalises a 48-bit significand product, rounds it to nearest
//             even and packs it into IEEE-754 single precision with saturation.
//  Revision : 1.0  initial release
// ============================================================================
module fp_norm_round (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        sign_in,
    input  logic [9:0]  exp_in,
    input  logic [47:0] mant_in,
    output logic [31:0] produto,
    output logic        done,
    output logic        busy,
    output logic        overflow,
    output logic        underflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2,
        S_PACK  = 2'd3
    } state_t;

    state_t      state_q,   state_d;
    logic        sign_q,    sign_d;
    logic [10:0] exp_q,     exp_d;
    logic [47:0] mant_q,    mant_d;
    logic [23:0] sig_q,     sig_d;
    logic        guard_q,   guard_d;
    logic        sticky_q,  sticky_d;
    logic        zero_q,    zero_d;
    logic [31:0] produto_q, produto_d;
    logic        done_q,    done_d;
    logic        ovf_q,     ovf_d;
    logic        unf_q,     unf_d;

    logic        round_up;
    logic [24:0] round_sum;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            sign_q    <= 1'b0;
            exp_q     <= 11'd0;
            mant_q    <= 48'd0;
            sig_q     <= 24'd0;
            guard_q   <= 1'b0;
            sticky_q  <= 1'b0;
            zero_q    <= 1'b0;
            produto_q <= 32'd0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            exp_q     <= exp_d;
            mant_q    <= mant_d;
            sig_q     <= sig_d;
            guard_q   <= guard_d;
            sticky_q  <= sticky_d;
            zero_q    <= zero_d;
            produto_q <= produto_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        mant_d    = mant_q;
        sig_d     = sig_q;
        guard_d   = guard_q;
        sticky_d  = sticky_q;
        zero_d    = zero_q;
        produto_d = produto_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        done_d    = 1'b0;
        round_up  = guard_q & (sticky_q | sig_q[0]);
        round_sum = {1'b0, sig_q} + {24'd0, round_up};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sign_d  = sign_in;
                    // Sign-extend so a +2 adjustment at the top of the range cannot wrap
                    exp_d   = {exp_in[9], exp_in};
                    mant_d  = mant_in;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                zero_d = (mant_q == 48'd0);
                if (mant_q[47]) begin
                    sig_d    = mant_q[47:24];
                    guard_d  = mant_q[23];
                    sticky_d = |mant_q[22:0];
                    exp_d    = exp_q + 11'd1;
                end else begin
                    sig_d    = mant_q[46:23];
                    guard_d  = mant_q[22];
                    sticky_d = |mant_q[21:0];
                end
                state_d = S_ROUND;
            end
            S_ROUND: begin
                if (round_sum[24]) begin
                    sig_d = round_sum[24:1];
                    exp_d = exp_q + 11'd1;
                end else begin
                    sig_d = round_sum[23:0];
                end
                state_d = S_PACK;
            end
            S_PACK: begin
                done_d = 1'b1;
                ovf_d  = 1'b0;
                unf_d  = 1'b0;
                if (zero_q) begin
                    produto_d = {sign_q, 31'd0};
                end else if ($signed(exp_q) >= $signed(11'd255)) begin
                    produto_d = {sign_q, 8'hFF, 23'd0};
                    ovf_d     = 1'b1;
                end else if ($signed(exp_q) <= $signed(11'd0)) begin
                    produto_d = {sign_q, 31'd0};
                    unf_d     = 1'b1;
                end else begin
                    produto_d = {sign_q, exp_q[7:0], sig_q[22:0]};
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign produto   = produto_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_norm_round.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_norm_round
//  Purpose  : Self-checking bench for fp_norm_round against an arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_norm_round;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        sign_in = 1'b0;
    logic [9:0]  exp_in = 10'd0;
    logic [47:0] mant_in = 48'd0;
    logic [31:0] produto;
    logic        done, busy, overflow, underflow;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    fp_norm_round dut (
        .clock(clock), .reset(reset), .start(start), .sign_in(sign_in),
        .exp_in(exp_in), .mant_in(mant_in), .produto(produto), .done(done),
        .busy(busy), .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    // Returns {produto, overflow, underflow} from plain integer arithmetic.
    function automatic logic [33:0] ref_model(input logic s, input logic [9:0] e_in,
                                              input logic [47:0] m);
        int e, sh;
        longint unsigned sig, rem, half, full;
        if (m == 48'd0) return {s, 31'd0, 2'b00};
        e    = int'($signed(e_in));
        full = 64'(m);
        sh   = m[47] ? 24 : 23;
        if (m[47]) e = e + 1;
        sig  = full >> sh;
        rem  = full - (sig << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && sig[0])) sig = sig + 1;
        if (sig == (64'd1 << 24)) begin
            sig = sig >> 1;
            e   = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0, 2'b10};
        if (e <= 0)   return {s, 31'd0, 2'b01};
        return {s, e[7:0], sig[22:0], 2'b00};
    endfunction

    // Expected-output tracker: an operation completes three edges after acceptance.
    int          m_cnt = 0;
    logic        m_sign = 1'b0;
    logic [9:0]  m_exp = 10'd0;
    logic [47:0] m_mant = 48'd0;
    logic [31:0] e_prod = 32'd0;
    logic        e_ovf = 1'b0, e_unf = 1'b0, e_done = 1'b0;

    always @(posedge clock) begin
        if (!reset) begin
            m_cnt  <= 0;
            e_prod <= 32'd0;
            e_ovf  <= 1'b0;
            e_unf  <= 1'b0;
            e_done <= 1'b0;
        end else begin
            e_done <= 1'b0;
            if (m_cnt == 0) begin
                if (start) begin
                    m_sign <= sign_in;
                    m_exp  <= exp_in;
                    m_mant <= mant_in;
                    m_cnt  <= 1;
                end
            end else if (m_cnt == 3) begin
                {e_prod, e_ovf, e_unf} <= ref_model(m_sign, m_exp, m_mant);
                e_done <= 1'b1;
                m_cnt  <= 0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            n_cmp++;
            if ({produto, done, busy, overflow, underflow} !==
                {e_prod, e_done, (m_cnt != 0), e_ovf, e_unf}) begin
                n_err++;
                $display("FAIL cycle_cmp t=%0t got prod=%h done=%b busy=%b ovf=%b unf=%b want prod=%h done=%b busy=%b ovf=%b unf=%b",
                         $time, produto, done, busy, overflow, underflow,
                         e_prod, e_done, (m_cnt != 0), e_ovf, e_unf);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy === 1'b1 && k < 10) begin
            @(negedge clock);
            k++;
        end
    endtask

    // Issue one operation and check the result against a literal expectation.
    task automatic directed(input string name, input logic s, input logic [9:0] e,
                            input logic [47:0] m, input logic [31:0] want_p,
                            input logic want_o, input logic want_u);
        bit seen = 1'b0;
        wait_idle();
        check({name, "_model"}, 64'(ref_model(s, e, m)), 64'({want_p, want_o, want_u}));
        sign_in = s; exp_in = e; mant_in = m; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check({name, "_busy"}, 64'(busy), 64'd1);
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clock);
            if (done === 1'b1) seen = 1'b1;
        end
        check({name, "_done"}, 64'(seen), 64'd1);
        check({name, "_prod"}, 64'(produto), 64'(want_p));
        check({name, "_flags"}, 64'({overflow, underflow}), 64'({want_o, want_u}));
        @(negedge clock);
        check({name, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    function automatic logic [47:0] rand_mant();
        logic [47:0] m;
        m = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0: m[47] = 1'b1;
            1: m[47:46] = 2'b01;
            2: m = {1'b0, 24'($urandom) | 24'h800000, 1'b1, 22'd0};
            3: m = {2'b01, 23'h7FFFFF, 23'($urandom_range(0, 3)) << 21};
            4: m = ($urandom_range(0, 3) == 0) ? 48'd0 : m;
            default: ;
        endcase
        return m;
    endfunction

    initial begin
        int dcount, last, gap;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        chk_en = 1'b1;
        @(negedge clock);
        check("reset_state", 64'({produto, done, busy, overflow, underflow}), 64'd0);
        reset = 1'b1;
        @(negedge clock);

        directed("mul_1p5",   1'b0, 10'd127, 48'h900000000000, 32'h40100000, 1'b0, 1'b0);
        directed("mul_1p0",   1'b0, 10'd127, 48'h400000000000, 32'h3F800000, 1'b0, 1'b0);
        directed("tie_odd",   1'b0, 10'd127, {1'b0, 24'h800001, 1'b1, 22'd0}, 32'h3F800002, 1'b0, 1'b0);
        directed("tie_even",  1'b0, 10'd127, {1'b0, 24'h800000, 1'b1, 22'd0}, 32'h3F800000, 1'b0, 1'b0);
        directed("rnd_carry", 1'b0, 10'd127, {1'b0, 24'hFFFFFF, 1'b1, 22'd0}, 32'h40000000, 1'b0, 1'b0);
        directed("overflow",  1'b1, 10'd254, 48'h900000000000, 32'hFF800000, 1'b1, 1'b0);
        directed("underflow", 1'b0, 10'h3F0, 48'h400000000000, 32'h00000000, 1'b0, 1'b1);
        directed("zero",      1'b1, 10'd127, 48'd0,            32'h80000000, 1'b0, 1'b0);
        directed("exp_top",   1'b0, 10'd511, {1'b1, 24'hFFFFFF, 23'h7FFFFF}, 32'h7F800000, 1'b1, 1'b0);
        directed("exp_bot",   1'b0, 10'h200, 48'h900000000000, 32'h00000000, 1'b0, 1'b1);

        // Abort at E2: reset sampled low on the second edge after acceptance.
        wait_idle();
        sign_in = 1'b0; exp_in = 10'd127; mant_in = 48'h900000000000; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("abort_state", 64'({produto, done, busy, overflow, underflow}), 64'd0);
        reset = 1'b1;
        dcount = 0;
        repeat (6) begin
            @(negedge clock);
            if (done === 1'b1) dcount++;
        end
        check("abort_no_done", 64'(dcount), 64'd0);

        // Start held high: a result every four cycles.
        dcount = 0; last = -1; gap = 4;
        start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            sign_in = 1'($urandom); exp_in = 10'($urandom_range(100, 160)); mant_in = rand_mant();
            @(negedge clock);
            if (done === 1'b1) begin
                if (last >= 0 && (c - last) != 4) gap = c - last;
                last = c;
                dcount++;
            end
        end
        start = 1'b0;
        check("b2b_count", 64'(dcount), 64'd10);
        check("b2b_gap", 64'(gap), 64'd4);

        // Random traffic with idle gaps and starts asserted while busy.
        for (int i = 0; i < 300; i++) begin
            sign_in = 1'($urandom);
            exp_in  = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 300));
            mant_in = rand_mant();
            start   = ($urandom_range(0, 2) != 0);
            @(negedge clock);
        end
        start = 1'b0;
        repeat (6) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
